// File: rtl/wb_clint.sv
// Core-local interruptor: 64-bit mtime/mtimecmp and msip behind a Wishbone classic slave.
// One-cycle ack/err; a held strobe is accepted every other cycle.
module wb_clint #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          TICK_DIV  = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wbs_addr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        xint_mtip_o,
  output logic        xint_msip_o
);

  localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [63:0]   mtime, mtime_nxt;
  logic [63:0]   mtimecmp, mtimecmp_nxt;
  logic [PW-1:0] pcnt;
  logic          msip, msip_nxt;
  logic [15:0]   off;
  logic          req, wr, tick, mapped;
  logic          hit_msip, hit_cmp_lo, hit_cmp_hi, hit_time_lo, hit_time_hi;
  logic [31:0]   rd_dat;
  logic          unused_addr;

  assign unused_addr = &{1'b0, wbs_addr_i[1:0]};

  assign off = {wbs_addr_i[15:2], 2'b00};
  assign req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o &
               (wbs_addr_i[31:16] == BASE_ADDR[31:16]);

  assign hit_msip    = (off == 16'h0000);
  assign hit_cmp_lo  = (off == 16'h4000);
  assign hit_cmp_hi  = (off == 16'h4004);
  assign hit_time_lo = (off == 16'hBFF8);
  assign hit_time_hi = (off == 16'hBFFC);
  assign mapped      = hit_msip | hit_cmp_lo | hit_cmp_hi | hit_time_lo | hit_time_hi;

  assign wr   = req & wbs_we_i & mapped;
  assign tick = (pcnt == PMAX);

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // A software write to either mtime word swallows that cycle's increment for all 64 bits.
  always_comb begin
    mtime_nxt    = mtime;
    mtimecmp_nxt = mtimecmp;
    msip_nxt     = msip;
    if (wr && hit_time_lo)
      mtime_nxt[31:0] = lanes(mtime[31:0], wbs_dat_i, wbs_sel_i);
    else if (wr && hit_time_hi)
      mtime_nxt[63:32] = lanes(mtime[63:32], wbs_dat_i, wbs_sel_i);
    else if (tick)
      mtime_nxt = mtime + 64'd1;
    if (wr && hit_cmp_lo)
      mtimecmp_nxt[31:0] = lanes(mtimecmp[31:0], wbs_dat_i, wbs_sel_i);
    if (wr && hit_cmp_hi)
      mtimecmp_nxt[63:32] = lanes(mtimecmp[63:32], wbs_dat_i, wbs_sel_i);
    if (wr && hit_msip && wbs_sel_i[0])
      msip_nxt = wbs_dat_i[0];
  end

  always_comb begin
    rd_dat = 32'h0;
    if (hit_msip)    rd_dat = {31'h0, msip};
    if (hit_cmp_lo)  rd_dat = mtimecmp[31:0];
    if (hit_cmp_hi)  rd_dat = mtimecmp[63:32];
    if (hit_time_lo) rd_dat = mtime[31:0];
    if (hit_time_hi) rd_dat = mtime[63:32];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime       <= 64'h0;
      mtimecmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
      pcnt        <= '0;
      msip        <= 1'b0;
      wbs_ack_o   <= 1'b0;
      wbs_err_o   <= 1'b0;
      wbs_dat_o   <= 32'h0;
      xint_mtip_o <= 1'b0;
    end else begin
      pcnt        <= tick ? '0 : pcnt + 1'b1;
      mtime       <= mtime_nxt;
      mtimecmp    <= mtimecmp_nxt;
      msip        <= msip_nxt;
      wbs_ack_o   <= req & mapped;
      wbs_err_o   <= req & ~mapped;
      wbs_dat_o   <= (req & mapped & ~wbs_we_i) ? rd_dat : 32'h0;
      xint_mtip_o <= (mtime_nxt >= mtimecmp_nxt);
    end
  end

  assign xint_msip_o = msip;

endmodule

// File: tb/tb_wb_clint.sv
// Bench for wb_clint: two instances (TICK_DIV 1 and 4) share one bus; a reference model
// predicts register state and a queue of expected responses is drained as ack/err appear.
module tb_wb_clint;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst, cyc, stb, we;
  logic [31:0] addr, wdat;
  logic [3:0]  sel;
  logic [31:0] dat_o [2];
  logic        ack_o [2];
  logic        err_o [2];
  logic        mtip  [2];
  logic        msip  [2];

  always #5 clk = ~clk;

  wb_clint #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .wbs_addr_i(addr), .wbs_dat_i(wdat), .wbs_sel_i(sel),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_dat_o(dat_o[0]),
    .wbs_ack_o(ack_o[0]), .wbs_err_o(err_o[0]), .xint_mtip_o(mtip[0]), .xint_msip_o(msip[0]));

  wb_clint #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .wbs_addr_i(addr), .wbs_dat_i(wdat), .wbs_sel_i(sel),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_dat_o(dat_o[1]),
    .wbs_ack_o(ack_o[1]), .wbs_err_o(err_o[1]), .xint_mtip_o(mtip[1]), .xint_msip_o(msip[1]));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] mtime;
    logic [63:0] cmp;
    int          pcnt;
    logic        msip;
    logic        pend;
  } model_t;

  typedef struct {
    logic        err;
    logic        chk_dat;
    logic [31:0] dat;
  } exp_t;

  model_t m0, m1;
  exp_t   q0[$], q1[$];
  logic   mon_en = 1'b0;
  int     n_resp0 = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic model_t step(input model_t m, input int div, input logic r, input logic c,
                                  input logic s, input logic w, input logic [31:0] a,
                                  input logic [31:0] d, input logic [3:0] be);
    model_t n;
    logic   rq, tk;
    n = m;
    if (r) begin
      n.mtime = 64'h0; n.cmp = '1; n.pcnt = 0; n.msip = 1'b0; n.pend = 1'b0;
      return n;
    end
    rq = c && s && !m.pend && (a[31:16] == BASE[31:16]);
    tk = (m.pcnt == div - 1);
    n.pcnt = tk ? 0 : m.pcnt + 1;
    n.pend = rq;
    if (tk) n.mtime = m.mtime + 64'd1;
    if (rq && w) begin
      case ({a[15:2], 2'b00})
        16'h0000: if (be[0]) n.msip = d[0];
        16'h4000: n.cmp[31:0]  = merge(m.cmp[31:0], d, be);
        16'h4004: n.cmp[63:32] = merge(m.cmp[63:32], d, be);
        16'hBFF8: n.mtime = {m.mtime[63:32], merge(m.mtime[31:0], d, be)};
        16'hBFFC: n.mtime = {merge(m.mtime[63:32], d, be), m.mtime[31:0]};
        default: ;
      endcase
    end
    return n;
  endfunction

  function automatic exp_t mk(input model_t m, input logic w, input logic [31:0] a);
    exp_t e;
    e.err = 1'b0;
    e.dat = 32'h0;
    case ({a[15:2], 2'b00})
      16'h0000: e.dat = {31'h0, m.msip};
      16'h4000: e.dat = m.cmp[31:0];
      16'h4004: e.dat = m.cmp[63:32];
      16'hBFF8: e.dat = m.mtime[31:0];
      16'hBFFC: e.dat = m.mtime[63:32];
      default:  e.err = 1'b1;
    endcase
    e.chk_dat = !w || e.err;
    return e;
  endfunction

  always @(posedge clk) begin
    m0 <= step(m0, 1, rst, cyc, stb, we, addr, wdat, sel);
    m1 <= step(m1, 4, rst, cyc, stb, we, addr, wdat, sel);
  end

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("mtip0", mtip[0], m0.mtime >= m0.cmp);
      chk("msip0", msip[0], m0.msip);
      chk("mtip1", mtip[1], m1.mtime >= m1.cmp);
      chk("msip1", msip[1], m1.msip);
      if (q0.size() == 0) chk("idle_resp0", {ack_o[0], err_o[0]}, 0);
      else if (ack_o[0] || err_o[0]) begin
        chk("resp_err0", err_o[0], q0[0].err);
        chk("resp_ack0", ack_o[0], !q0[0].err);
        if (q0[0].chk_dat) chk("resp_dat0", dat_o[0], q0[0].dat);
        void'(q0.pop_front());
        n_resp0++;
      end
      if (q1.size() == 0) chk("idle_resp1", {ack_o[1], err_o[1]}, 0);
      else if (ack_o[1] || err_o[1]) begin
        chk("resp_err1", err_o[1], q1[0].err);
        chk("resp_ack1", ack_o[1], !q1[0].err);
        if (q1[0].chk_dat) chk("resp_dat1", dat_o[1], q1[0].dat);
        void'(q1.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input logic w, input logic [31:0] a);
    if (a[31:16] == BASE[31:16]) begin
      q0.push_back(mk(m0, w, a));
      q1.push_back(mk(m1, w, a));
    end
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d; sel = s;
    push(w, a);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk); #1;
    chk("resp_seen0", q0.size(), 0);
    chk("resp_seen1", q1.size(), 0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    chk("dat_idle0", dat_o[0], 0);
    chk("dat_idle1", dat_o[1], 0);
  endtask

  task automatic rd(input logic [15:0] o);
    xfer(1'b0, BASE | {16'h0, o}, 32'h0, 4'hF);
  endtask

  task automatic wr(input logic [15:0] o, input logic [31:0] d, input logic [3:0] s);
    xfer(1'b1, BASE | {16'h0, o}, d, s);
  endtask

  initial begin
    int r0;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = 32'h0; wdat = 32'h0; sel = 4'h0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    // A request presented during reset must leave no trace.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = BASE; wdat = 32'hFFFF_FFFF; sel = 4'hF;
    repeat (3) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("rst_dat%0d", u), dat_o[u], 0);
        chk($sformatf("rst_mtip%0d", u), mtip[u], 0);
        chk($sformatf("rst_msip%0d", u), msip[u], 0);
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;

    repeat (10) @(posedge clk);
    rd(16'hBFF8);
    chk("mtip_idle", mtip[0], 0);

    // Compare and timer interrupt.
    wr(16'h4000, 32'd20, 4'hF);
    wr(16'h4004, 32'd0, 4'hF);
    for (int i = 0; i < 100 && !mtip[0]; i++) @(negedge clk);
    chk("mtip_rise", mtip[0], 1);
    wr(16'h4004, 32'd1, 4'hF);
    chk("mtip_fall", mtip[0], 0);

    // 64-bit wrap.
    wr(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
    wr(16'hBFF8, 32'hFFFF_FFF0, 4'hF);
    repeat (20) @(posedge clk);
    rd(16'hBFFC);
    rd(16'hBFF8);

    // Software interrupt, only lane 0 matters.
    wr(16'h0000, 32'hFFFF_FFFF, 4'b0001);
    chk("msip_set", msip[0], 1);
    rd(16'h0000);
    wr(16'h0000, 32'h0, 4'b1110);
    rd(16'h0000);
    wr(16'h0000, 32'h0, 4'hF);
    chk("msip_clr", msip[0], 0);

    // Prescaler and low-to-high carry.
    wr(16'hBFFC, 32'h0, 4'hF);
    wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    repeat (4) @(posedge clk);
    rd(16'hBFFC);
    rd(16'hBFF8);
    // Writes landing on a tick cycle of the divided instance.
    for (int i = 0; i < 8 && m1.pcnt != 2; i++) @(negedge clk);
    wr(16'hBFF8, 32'd100, 4'hF);
    rd(16'hBFF8);
    for (int i = 0; i < 8 && m1.pcnt != 2; i++) @(negedge clk);
    wr(16'hBFFC, 32'd5, 4'hF);
    rd(16'hBFF8);
    rd(16'hBFFC);

    // Byte lanes.
    wr(16'h4000, 32'hFFFF_FFFF, 4'hF);
    wr(16'h4000, 32'hAABB_CCDD, 4'b0110);
    rd(16'h4000);

    // Unmapped offsets and out-of-window accesses.
    rd(16'h1000);
    wr(16'h1000, 32'h0, 4'hF);
    wr(16'h4008, 32'h0, 4'hF);
    xfer(1'b1, 32'h0300_4000, 32'h1234_5678, 4'hF);
    rd(16'h4000);

    // Strobe held for six cycles.
    r0 = n_resp0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = BASE | 32'h4000; sel = 4'hF;
    repeat (3) push(1'b0, addr);
    repeat (6) @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("held_acks", n_resp0 - r0, 3);
    chk("held_drain", q0.size(), 0);
    q0.delete();
    q1.delete();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end

endmodule
